// File: rtl/pipeline_pkg.sv
// Shared pipeline types and widths for the MEM stage.
// Holds the MEM-stage FSM state type and the MEM/WB bundle.
package pipeline_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int TO_CNT_W   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [XLEN-1:0]       wb_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB output register bank with load enable and bubble insert.
// A bubble clears only regwrite; data and rd keep their last value.
module mem_wb_reg
  import pipeline_pkg::*;
#(
  parameter int XLEN       = pipeline_pkg::XLEN,
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_bubble,
  input  logic [XLEN-1:0]       i_wb_data,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_regwrite,
  output logic [XLEN-1:0]       o_wb_data,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  o_regwrite
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_wb_data  <= '0;
      o_rd       <= '0;
      o_regwrite <= 1'b0;
    end else if (i_load) begin
      o_wb_data  <= i_wb_data;
      o_rd       <= i_rd;
      o_regwrite <= i_regwrite;
    end else if (i_bubble) begin
      o_regwrite <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack controller and MEM/WB register.
// MEM_TIMEOUT_EN adds a BUSY watchdog and the sticky MEM_WB_err flag.
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN           = pipeline_pkg::XLEN,
  parameter int REG_ADDR_W     = pipeline_pkg::REG_ADDR_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       EX_MEM_ALU_result,
  input  logic [XLEN-1:0]       EX_MEM_rs2_data,
  input  logic [REG_ADDR_W-1:0] EX_MEM_rd,
  input  logic                  EX_MEM_regwrite,
  input  logic                  EX_MEM_memtoreg,
  input  logic                  EX_MEM_memread,
  input  logic                  EX_MEM_memwrite,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  MEM_stall,
  output logic [XLEN-1:0]       MEM_WB_wb_data,
  output logic [REG_ADDR_W-1:0] MEM_WB_rd,
  output logic                  MEM_WB_regwrite,
  output logic                  MEM_WB_err
);

  mem_state_t            r_state;
  mem_state_t            w_state_nxt;
  logic                  r_req, r_we;
  logic [XLEN-1:0]       r_addr, r_wdata;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_regwrite, r_memtoreg;

  logic                  w_access, w_is_load;
  logic                  w_req_nxt, w_we_nxt;
  logic [XLEN-1:0]       w_addr_nxt, w_wdata_nxt;
  logic                  w_cap, w_timeout;
  logic                  w_wb_load, w_wb_bubble;
  logic [XLEN-1:0]       w_wb_data;
  logic [REG_ADDR_W-1:0] w_wb_rd;
  logic                  w_wb_rw;

  assign w_access  = EX_MEM_memread | EX_MEM_memwrite;
  assign w_is_load = EX_MEM_memread & ~EX_MEM_memwrite;

  assign MEM_stall = ((r_state == IDLE) & w_access)
                   | ((r_state == BUSY) & ~dmem_ack);

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;

`ifdef MEM_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_cnt;
  logic                r_err;

  assign w_timeout = (r_state == BUSY) & ~dmem_ack
                   & (r_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
  assign MEM_WB_err = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_cap)
        r_cnt <= '0;
      else if ((r_state == BUSY) & ~dmem_ack)
        r_cnt <= r_cnt + 1'b1;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end
`else
  assign w_timeout  = 1'b0;
  assign MEM_WB_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_cap       = 1'b0;
    w_wb_load   = 1'b0;
    w_wb_bubble = 1'b0;
    w_wb_data   = EX_MEM_ALU_result;
    w_wb_rd     = EX_MEM_rd;
    w_wb_rw     = EX_MEM_regwrite;
    unique case (r_state)
      IDLE: begin
        if (w_access) begin
          w_state_nxt = BUSY;
          w_req_nxt   = 1'b1;
          w_we_nxt    = EX_MEM_memwrite;
          w_addr_nxt  = EX_MEM_ALU_result;
          w_wdata_nxt = EX_MEM_rs2_data;
          w_cap       = 1'b1;
          w_wb_bubble = 1'b1;
        end else begin
          w_wb_load = 1'b1;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_wb_load   = 1'b1;
          w_wb_data   = r_memtoreg ? dmem_rdata : r_addr;
          w_wb_rd     = r_rd;
          w_wb_rw     = r_regwrite;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_wb_bubble = 1'b1;
        end else begin
          w_wb_bubble = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  // Store wins over load; a load to x0 never writes back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
    end else if (w_cap) begin
      r_rd       <= EX_MEM_rd;
      r_regwrite <= EX_MEM_regwrite
                  & ~(w_is_load & (EX_MEM_rd == '0));
      r_memtoreg <= EX_MEM_memtoreg & ~EX_MEM_memwrite;
    end
  end

  mem_wb_reg #(
    .XLEN      (XLEN),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_mem_wb_reg (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_wb_load),
    .i_bubble  (w_wb_bubble),
    .i_wb_data (w_wb_data),
    .i_rd      (w_wb_rd),
    .i_regwrite(w_wb_rw),
    .o_wb_data (MEM_WB_wb_data),
    .o_rd      (MEM_WB_rd),
    .o_regwrite(MEM_WB_regwrite)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU vector table plus
// hand-written load/store/reset/timeout sequences.
module tb_mem_access_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu, rs2, rdata;
  logic [4:0]  rd;
  logic        regwrite, memtoreg, memread, memwrite, ack;
  logic        dmem_req, dmem_we, MEM_stall;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [4:0]  wb_rd;
  logic        wb_rw, wb_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .XLEN          (32),
    .REG_ADDR_W    (5),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .EX_MEM_ALU_result(alu),
    .EX_MEM_rs2_data  (rs2),
    .EX_MEM_rd        (rd),
    .EX_MEM_regwrite  (regwrite),
    .EX_MEM_memtoreg  (memtoreg),
    .EX_MEM_memread   (memread),
    .EX_MEM_memwrite  (memwrite),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_ack         (ack),
    .dmem_rdata       (rdata),
    .MEM_stall        (MEM_stall),
    .MEM_WB_wb_data   (wb_data),
    .MEM_WB_rd        (wb_rd),
    .MEM_WB_regwrite  (wb_rw),
    .MEM_WB_err       (wb_err)
  );

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    mem_wb_t     exp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu = '0; rs2 = '0; rd = '0; rdata = '0;
    regwrite = 0; memtoreg = 0; memread = 0;
    memwrite = 0; ack = 0;
  endtask

  int n_stall;
  int n_busy;

  initial begin
    vecs[0] = '{32'h0000_1234, 5'd5,  1'b1,
                '{32'h0000_1234, 5'd5,  1'b1}};
    vecs[1] = '{32'hFFFF_FFFF, 5'd31, 1'b0,
                '{32'hFFFF_FFFF, 5'd31, 1'b0}};
    vecs[2] = '{32'h8000_0001, 5'd0,  1'b1,
                '{32'h8000_0001, 5'd0,  1'b1}};
    vecs[3] = '{32'h0000_0000, 5'd12, 1'b1,
                '{32'h0000_0000, 5'd12, 1'b1}};

    idle_in();
    reset = 1'b0;
    #3;
    chk("rst_req", {31'b0, dmem_req}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_we", {31'b0, dmem_we}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rw", {31'b0, wb_rw}, 0);
    chk("rst_err", {31'b0, wb_err}, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // ALU-only table
    for (int i = 0; i < 4; i++) begin
      alu = vecs[i].alu; rd = vecs[i].rd; regwrite = vecs[i].rw;
      @(negedge clk);
      chk($sformatf("alu%0d_stall", i), {31'b0, MEM_stall}, 0);
      step();
      chk($sformatf("alu%0d_data", i), wb_data, vecs[i].exp.wb_data);
      chk($sformatf("alu%0d_rd", i), {27'b0, wb_rd},
          {27'b0, vecs[i].exp.rd});
      chk($sformatf("alu%0d_rw", i), {31'b0, wb_rw},
          {31'b0, vecs[i].exp.regwrite});
    end

    // Load with three wait cycles
    idle_in();
    memread = 1; memtoreg = 1; alu = 32'h100; rd = 7; regwrite = 1;
    n_stall = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (MEM_stall) n_stall++;
      if (c > 0) begin
        chk("ld_req", {31'b0, dmem_req}, 1);
        chk("ld_addr", dmem_addr, 32'h100);
        chk("ld_we", {31'b0, dmem_we}, 0);
        chk("ld_bubble", {31'b0, wb_rw}, 0);
      end
      step();
    end
    ack = 1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    if (MEM_stall) n_stall++;
    chk("ld_stall_cycles", n_stall, 4);
    step();
    idle_in();
    chk("ld_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_rd", {27'b0, wb_rd}, 7);
    chk("ld_rw", {31'b0, wb_rw}, 1);
    chk("ld_req_drop", {31'b0, dmem_req}, 0);

    // Store, immediate ack
    memwrite = 1; alu = 32'h200; rs2 = 32'hA5A5_A5A5; rd = 4;
    @(negedge clk);
    chk("st_stall_idle", {31'b0, MEM_stall}, 1);
    step();
    ack = 1;
    @(negedge clk);
    chk("st_req", {31'b0, dmem_req}, 1);
    chk("st_we", {31'b0, dmem_we}, 1);
    chk("st_addr", dmem_addr, 32'h200);
    chk("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
    chk("st_stall_ack", {31'b0, MEM_stall}, 0);
    step();
    idle_in();
    chk("st_we_drop", {31'b0, dmem_we}, 0);
    chk("st_req_drop", {31'b0, dmem_req}, 0);
    chk("st_rw", {31'b0, wb_rw}, 0);

    // Read+write together: store wins, rdata ignored
    memread = 1; memwrite = 1; memtoreg = 1; regwrite = 1;
    rd = 6; alu = 32'h240; rs2 = 32'h1357_9BDF;
    step();
    chk("rw_we", {31'b0, dmem_we}, 1);
    ack = 1; rdata = 32'h1111_1111;
    step();
    idle_in();
    chk("rw_data", wb_data, 32'h240);
    chk("rw_rw", {31'b0, wb_rw}, 1);

    // Load to x0
    memread = 1; memtoreg = 1; rd = 0; regwrite = 1; alu = 32'h104;
    step();
    ack = 1; rdata = 32'h0000_CAFE;
    step();
    idle_in();
    chk("ld_x0_rw", {31'b0, wb_rw}, 0);

    // Stray ack while idle
    alu = 32'h77; rd = 2; regwrite = 1; ack = 1; rdata = 32'h999;
    @(negedge clk);
    chk("idle_ack_stall", {31'b0, MEM_stall}, 0);
    step();
    ack = 0;
    chk("idle_ack_req", {31'b0, dmem_req}, 0);
    chk("idle_ack_data", wb_data, 32'h77);
    step();
    chk("idle_ack_req2", {31'b0, dmem_req}, 0);

    // Reset in the middle of a BUSY access
    idle_in();
    alu = 32'h3C; rd = 3; regwrite = 1;
    step();
    chk("pre_rst_data", wb_data, 32'h3C);
    memread = 1; alu = 32'h400; rd = 8;
    step();
    @(negedge clk);
    chk("mid_busy_req", {31'b0, dmem_req}, 1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, dmem_req}, 0);
    chk("mid_rst_addr", dmem_addr, 0);
    chk("mid_rst_data", wb_data, 0);
    chk("mid_rst_rd", {27'b0, wb_rd}, 0);
    idle_in();
    alu = 32'h55; rd = 3; regwrite = 1;
    @(negedge clk);
    reset = 1'b1;
    chk("post_rst_stall", {31'b0, MEM_stall}, 0);
    step();
    chk("post_rst_data", wb_data, 32'h55);
    chk("post_rst_rw", {31'b0, wb_rw}, 1);
    chk("post_rst_req", {31'b0, dmem_req}, 0);

`ifdef MEM_TIMEOUT_EN
    // Watchdog expiry, no ack
    idle_in();
    memread = 1; memtoreg = 1; rd = 9; regwrite = 1; alu = 32'h300;
    @(negedge clk);
    chk("to_err_pre", {31'b0, wb_err}, 0);
    step();
    n_busy = 0;
    for (int c = 0; c < 20 && dmem_req; c++) begin
      n_busy++;
      step();
    end
    memread = 0;
    chk("to_busy_cycles", n_busy, 4);
    chk("to_req", {31'b0, dmem_req}, 0);
    chk("to_err", {31'b0, wb_err}, 1);
    chk("to_bubble", {31'b0, wb_rw}, 0);
    step();
    chk("to_err_sticky", {31'b0, wb_err}, 1);

    // Ack on the expiry cycle completes normally
    reset = 1'b0;
    #2;
    chk("to_rst_err", {31'b0, wb_err}, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    memread = 1; memtoreg = 1; rd = 9; regwrite = 1; alu = 32'h300;
    for (int c = 0; c < 4; c++) step();
    ack = 1; rdata = 32'h0BAD_F00D;
    step();
    idle_in();
    chk("to_ack_data", wb_data, 32'h0BAD_F00D);
    chk("to_ack_rw", {31'b0, wb_rw}, 1);
    chk("to_ack_err", {31'b0, wb_err}, 0);
`else
    @(negedge clk);
    chk("no_to_err", {31'b0, wb_err}, 0);
    n_busy = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
